// File: rtl/vram_scanout_fetch_pkg.sv
// Shared FSM encoding, default frame geometry and width helper for the vram scanout path.
// Also reused by the character generator so both sides agree on geometry.
package vram_scanout_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  localparam int DEF_ADDRWIDTH  = 10;
  localparam int DEF_BASE_ADDR  = 0;
  localparam int DEF_LINE_BYTES = 40;
  localparam int DEF_NUM_LINES  = 25;
  localparam int DEF_FIFO_DEPTH = 8;

  // One vram byte plus its line_end tag.
  localparam int FIFO_WIDTH = 9;

  // Counter width for values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Synchronous FIFO for the scanout path: data + line_end tag, occupancy count output.
// Head is read straight from the storage registers, so a write is visible one cycle later.
module scanout_fifo
  import vram_scanout_fetch_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is not reset; entries are only observed after being written, so a reset here would just cost flops.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vram_scanout_fetch.sv
// Display-side vram read engine: walks a frame through vram port B into a FIFO and streams it out.
// Optional SCANOUT_DOUBLE_SCAN_EN fetches every line twice.
module vram_scanout_fetch
  import vram_scanout_fetch_pkg::*;
#(
  parameter int ADDRWIDTH  = DEF_ADDRWIDTH,
  parameter int BASE_ADDR  = DEF_BASE_ADDR,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_frame_start,
  output logic [ADDRWIDTH-1:0] out_baddr,
  input  logic [7:0]           in_bdata,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic                 out_line_end,
  output logic                 out_frame_done,
  output logic                 out_busy,
  output logic                 out_underrun
);

  localparam int CW  = cnt_width(LINE_BYTES);
  localparam int RW  = cnt_width(NUM_LINES);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0]        COL_LAST = CW'(LINE_BYTES - 1);
  localparam logic [RW-1:0]        ROW_LAST = RW'(NUM_LINES - 1);
  localparam logic [ADDRWIDTH-1:0] BASE     = ADDRWIDTH'(BASE_ADDR);
  localparam logic [ADDRWIDTH-1:0] STRIDE   = ADDRWIDTH'(LINE_BYTES);

  scan_state_e          state;
  scan_state_e          state_next;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [ADDRWIDTH-1:0] line_base;
  logic                 inflight;
  logic                 inflight_tag;
  logic [FCW-1:0]       fifo_count;
  logic                 fifo_empty;
  logic [8:0]           fifo_head;
  logic                 issue;
  logic                 col_at_end;
  logic                 line_done;
  logic                 last_issue;
  logic                 fetch_entry;
  logic                 pop;

  assign fetch_entry = (state == ST_IDLE) && in_frame_start;
  assign col_at_end  = (col == COL_LAST);

`ifdef SCANOUT_DOUBLE_SCAN_EN
  logic second_pass;
  assign line_done = col_at_end & second_pass;
`else
  assign line_done = col_at_end;
`endif

  // Counting the read in flight keeps the FIFO from ever being over-committed.
  assign issue      = (state == ST_FETCH) &&
                      ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));
  assign last_issue = issue && line_done && (row == ROW_LAST);
  assign out_baddr  = line_base + ADDRWIDTH'(col);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_frame_start)             state_next = ST_FETCH;
      ST_FETCH: if (last_issue)                 state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !inflight)    state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    out_busy       = (state != ST_IDLE);
    out_frame_done = (state == ST_DRAIN) && fifo_empty && !inflight;
  end

  // Walkers rewind on frame start and after the final issue, so the idle address is BASE again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col       <= '0;
      row       <= '0;
      line_base <= BASE;
`ifdef SCANOUT_DOUBLE_SCAN_EN
      second_pass <= 1'b0;
`endif
    end else if (fetch_entry || last_issue) begin
      col       <= '0;
      row       <= '0;
      line_base <= BASE;
`ifdef SCANOUT_DOUBLE_SCAN_EN
      second_pass <= 1'b0;
`endif
    end else if (issue) begin
      if (!col_at_end) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
`ifdef SCANOUT_DOUBLE_SCAN_EN
        second_pass <= ~second_pass;
        if (second_pass) begin
          row       <= row + 1'b1;
          line_base <= line_base + STRIDE;
        end
`else
        row       <= row + 1'b1;
        line_base <= line_base + STRIDE;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight     <= 1'b0;
      inflight_tag <= 1'b0;
    end else begin
      inflight     <= issue;
      inflight_tag <= issue & col_at_end;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                       out_underrun <= 1'b0;
    else if (fetch_entry)                               out_underrun <= 1'b0;
    else if ((state == ST_FETCH) && in_ready && !out_valid) out_underrun <= 1'b1;
  end

  assign pop          = out_valid & in_ready;
  assign out_valid    = ~fifo_empty;
  assign out_data     = fifo_head[7:0];
  assign out_line_end = fifo_head[8] & out_valid;

  scanout_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (inflight),
    .wr_data ({inflight_tag, in_bdata}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_vram_scanout_fetch.sv
// Self-checking bench for vram_scanout_fetch: a frame model built from the geometry rules,
// checked every cycle, plus directed literal checks for latency, wrap, backpressure and reset.
`timescale 1ns/1ps
module tb_vram_scanout_fetch;

  localparam int AW    = 10;
  localparam int BASE  = 1022;
  localparam int LB    = 4;
  localparam int NL    = 4;
  localparam int DEPTH = 8;
`ifdef SCANOUT_DOUBLE_SCAN_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_frame_start = 1'b0;
  logic          in_ready = 1'b0;
  logic [AW-1:0] out_baddr;
  logic [7:0]    in_bdata = 8'h00;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_line_end;
  logic          out_frame_done;
  logic          out_busy;
  logic          out_underrun;

  int total = 0;
  int bad = 0;
  int done_count = 0;
  bit model_en = 1'b0;
  bit done_due = 1'b0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data;
  logic       prev_tag;
  logic [8:0] cmp_e;
  logic [8:0] exp_q[$];

  vram_scanout_fetch #(
    .ADDRWIDTH  (AW),
    .BASE_ADDR  (BASE),
    .LINE_BYTES (LB),
    .NUM_LINES  (NL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_frame_start (in_frame_start),
    .out_baddr      (out_baddr),
    .in_bdata       (in_bdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .out_line_end   (out_line_end),
    .out_frame_done (out_frame_done),
    .out_busy       (out_busy),
    .out_underrun   (out_underrun)
  );

  always #5 clock = ~clock;

  // vram contents: distinct per address, and BASE maps to 0 so the frame reads 0,1,2,...
  function automatic logic [7:0] vram_byte(input int addr);
    return 8'((addr + 2) % 256);
  endfunction

  always @(posedge clock) in_bdata <= vram_byte(int'(out_baddr));

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic build_frame();
    for (int l = 0; l < NL; l++)
      for (int p = 0; p < PASSES; p++)
        for (int c = 0; c < LB; c++)
          exp_q.push_back({(c == LB - 1) ? 1'b1 : 1'b0,
                           vram_byte((BASE + l * LB + c) % (1 << AW))});
  endtask

  task automatic pulse_start();
    in_frame_start = 1'b1;
    tick();
    in_frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit pattern);
    int c0;
    c0 = done_count;
    for (int i = 0; i < budget && done_count == c0; i++) begin
      if (pattern) in_ready = ((i % 3) != 1);
      tick();
    end
    check("frame_done_seen", done_count - c0, 1);
  endtask

  always @(negedge clock) begin
    if (model_en) begin
      check("frame_done", int'(out_frame_done), int'(done_due));
      done_due = 1'b0;
      if (out_frame_done) done_count++;
      if (prev_hold) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(prev_data));
        check("hold_tag", int'(out_line_end), int'(prev_tag));
      end
      if (out_valid && in_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got data %0d with nothing expected", out_data);
        end else begin
          cmp_e = exp_q.pop_front();
          check("data", int'(out_data), int'(cmp_e[7:0]));
          check("line_end", int'(out_line_end), int'(cmp_e[8]));
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
      prev_hold = out_valid && !in_ready;
      prev_data = out_data;
      prev_tag  = out_line_end;
    end else begin
      prev_hold = 1'b0;
      done_due  = 1'b0;
    end
  end

  initial begin
    int c_start;

    #12;
    check("rst_baddr", int'(out_baddr), BASE);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(out_busy), 0);
    check("rst_underrun", int'(out_underrun), 0);
    check("rst_frame_done", int'(out_frame_done), 0);
    check("rst_line_end", int'(out_line_end), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    // Frame in order, free-running consumer; pins the model and first-byte latency.
    build_frame();
    check("model_e3", int'(exp_q[3]), 9'h103);
`ifdef SCANOUT_DOUBLE_SCAN_EN
    check("model_e4", int'(exp_q[4]), 9'h000);
    check("model_e8", int'(exp_q[8]), 9'h004);
    check("model_e31", int'(exp_q[31]), 9'h10f);
`else
    check("model_e4", int'(exp_q[4]), 9'h004);
    check("model_e7", int'(exp_q[7]), 9'h107);
    check("model_e15", int'(exp_q[15]), 9'h10f);
`endif
    model_en = 1'b1;
    in_ready = 1'b1;
    pulse_start();
    check("t1_busy", int'(out_busy), 1);
    check("t1_valid_c0", int'(out_valid), 0);
    tick();
    check("t1_valid_c1", int'(out_valid), 0);
    tick();
    check("t1_valid_c2", int'(out_valid), 1);
    check("t1_first_data", int'(out_data), 0);
    wait_done(500, 1'b0);
    tick();
    check("t1_idle", int'(out_busy), 0);
    check("t1_underrun", int'(out_underrun), 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // Stalled consumer: address wrap, FIFO fills to depth, head held, then release.
    in_ready = 1'b0;
    build_frame();
    pulse_start();
    check("t2_addr0", int'(out_baddr), 1022);
    check("t2_underrun_cleared", int'(out_underrun), 0);
    tick();
    check("t2_addr1", int'(out_baddr), 1023);
    tick();
    check("t2_addr2", int'(out_baddr), 0);
    tick();
    check("t2_addr3", int'(out_baddr), 1);
    repeat (20) tick();
    check("t2_addr_full", int'(out_baddr), 6);
    check("t2_valid", int'(out_valid), 1);
    check("t2_head", int'(out_data), 0);
    check("t2_busy", int'(out_busy), 1);
    repeat (5) tick();
    check("t2_addr_hold", int'(out_baddr), 6);
    in_ready = 1'b1;
    wait_done(500, 1'b0);
    tick();
    check("t2_queue_empty", exp_q.size(), 0);

    // Restart request while fetching is ignored; intermittent consumer.
    build_frame();
    c_start = done_count;
    pulse_start();
    repeat (3) tick();
    in_frame_start = 1'b1;
    tick();
    in_frame_start = 1'b0;
    wait_done(500, 1'b1);
    in_ready = 1'b1;
    repeat (30) tick();
    check("t4_single_done", done_count - c_start, 1);
    check("t4_idle", int'(out_busy), 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // Asynchronous reset mid-fetch, then a clean frame from BASE.
    build_frame();
    pulse_start();
    repeat (6) tick();
    model_en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("t5_busy", int'(out_busy), 0);
    check("t5_valid", int'(out_valid), 0);
    check("t5_baddr", int'(out_baddr), BASE);
    check("t5_underrun", int'(out_underrun), 0);
    check("t5_line_end", int'(out_line_end), 0);
    check("t5_frame_done", int'(out_frame_done), 0);
    exp_q.delete();
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    model_en = 1'b1;
    build_frame();
    pulse_start();
    check("t5_restart_addr", int'(out_baddr), BASE);
    wait_done(500, 1'b0);
    tick();
    check("t5_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
